// File: rtl/fadd_arbiter_81.sv
// Round-robin arbiter that shares one registered float adder among NREQ requesters.
// Credits reserve a response FIFO slot at issue time, so results are never dropped.
module fadd_arbiter_81 #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                 clk81,
  input  logic                 reset_n81,
  input  logic [NREQ-1:0]      req_valid_81,
  output logic [NREQ-1:0]      req_ready_81,
  input  logic [32*NREQ-1:0]   req_a_81,
  input  logic [32*NREQ-1:0]   req_b_81,
  output logic [31:0]          add_a81,
  output logic [31:0]          add_b81,
  output logic                 add_reset_81,
  input  logic [31:0]          add_result_81,
  output logic                 rsp_valid_81,
  input  logic                 rsp_ready_81,
  output logic [IDW-1:0]       rsp_id_81,
  output logic [31:0]          rsp_data_81,
  output logic                 busy_81
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0]  rr_ptr_r;
  logic [LAT-1:0]  tag_v_r;
  logic [IDW-1:0]  tag_id_r [LAT];
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   count_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [IDW-1:0]  mem_id_r [DEPTH];
  logic [31:0]     mem_data_r [DEPTH];

  logic            credit_s;
  logic            hit_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic [IDW-1:0]  gnt_s;
  logic [2*NREQ-1:0] rot_s;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return IDW'(s);
  endfunction

  assign credit_s = ({1'b0, inflight_r} + {1'b0, count_r}) < (CW + 1)'(DEPTH);
  assign rot_s    = {req_valid_81, req_valid_81} >> rr_ptr_r;

  // Round-robin search starting at rr_ptr_r
  always_comb begin
    hit_s = 1'b0;
    gnt_s = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit_s && rot_s[k]) begin
        hit_s = 1'b1;
        gnt_s = wrap_add(rr_ptr_r, k);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  assign issue_s = reset_n81 & credit_s & hit_s;
  assign push_s  = tag_v_r[LAT-1];
  assign pop_s   = rsp_valid_81 & rsp_ready_81;

  // Grant vector and operand mux; operands stay zero when nothing issues
  always_comb begin
    req_ready_81 = '0;
    add_a81      = 32'h0;
    add_b81      = 32'h0;
    for (int k = 0; k < NREQ; k++) begin
      if (issue_s && (gnt_s == IDW'(k))) begin
        req_ready_81[k] = 1'b1;
        add_a81         = req_a_81[32*k +: 32];
        add_b81         = req_b_81[32*k +: 32];
      end else begin
        req_ready_81[k] = 1'b0;
      end
    end
  end

  // Arbitration pointer, tag pipe and in-flight counter
  always_ff @(posedge clk81 or negedge reset_n81) begin
    if (!reset_n81) begin
      rr_ptr_r   <= '0;
      tag_v_r    <= '0;
      inflight_r <= '0;
      for (int k = 0; k < LAT; k++) tag_id_r[k] <= '0;
    end else begin
      if (issue_s) rr_ptr_r <= wrap_add(gnt_s, 1);
      tag_v_r[0]  <= issue_s;
      tag_id_r[0] <= gnt_s;
      for (int k = 1; k < LAT; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
      case ({issue_s, push_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk81 or negedge reset_n81) begin
    if (!reset_n81) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are only visible while count_r is non-zero
  always_ff @(posedge clk81) begin
    if (push_s) begin
      mem_id_r[wr_ptr_r]   <= tag_id_r[LAT-1];
      mem_data_r[wr_ptr_r] <= add_result_81;
    end
  end

  assign add_reset_81 = ~reset_n81;
  assign rsp_valid_81 = reset_n81 & (count_r != '0);
  assign rsp_id_81    = rsp_valid_81 ? mem_id_r[rd_ptr_r]   : '0;
  assign rsp_data_81  = rsp_valid_81 ? mem_data_r[rd_ptr_r] : 32'h0;
  assign busy_81      = reset_n81 & ((inflight_r != '0) | (count_r != '0));

endmodule
